// File: rtl/dds_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : dds_ctrl_if                                          |
// | Description : Host command channel and waveform byte stream        |
// |               feeding the DDS controller.                          |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
interface dds_ctrl_if;
    // Host command channel
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;

    // Waveform byte stream
    logic        lut_valid;
    logic        lut_ready;
    logic [7:0]  lut_data;

    modport master (
        output cmd_valid, cmd_op, cmd_data, lut_valid, lut_data,
        input  cmd_ready, lut_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, lut_valid, lut_data,
        output cmd_ready, lut_ready
    );
endinterface
`default_nettype wire

// File: rtl/dds_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : dds_ctrl                                             |
// | Description : DDS controller - phase step programming, waveform    |
// |               LUT loading and linear frequency sweep.              |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module dds_ctrl #(
    parameter int LUT_DEPTH = 4096
) (
    input  wire         clk,
    input  wire         reset,
    dds_ctrl_if.slave   bus,
    output logic [7:0]  dds_cfg,
    output logic        dds_cfg_ce,
    output logic [31:0] dds_step,
    output logic [1:0]  state,
    output logic        load_done,
    output logic        sweep_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2,
        ST_SWEEP = 2'd3
    } state_t;

    localparam logic [1:0] OP_SET_STEP    = 2'd0;
    localparam logic [1:0] OP_LOAD_LUT    = 2'd1;
    localparam logic [1:0] OP_SET_STOP    = 2'd2;
    localparam logic [1:0] OP_START_SWEEP = 2'd3;

    localparam int              CNT_W     = $clog2(LUT_DEPTH);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(LUT_DEPTH - 1);

    state_t             cur_state, next_state;
    logic [31:0]        step_next;
    logic [31:0]        saved_step, saved_next;
    logic [31:0]        stop_step, stop_next;
    logic [CNT_W-1:0]   byte_cnt, byte_cnt_next;
    // The byte counter wraps to 0 on the last byte, so a separate flag
    // remembers that the full table has been taken.
    logic               load_full, load_full_next;
    logic [15:0]        dwell, dwell_next;
    logic [15:0]        dwell_cnt, dwell_cnt_next;
    logic [15:0]        inc, inc_next;
    logic               load_done_next;
    logic               sweep_done_next;
    logic [32:0]        sum;
    logic               cmd_fire;
    logic               lut_fire;

    assign bus.cmd_ready = (cur_state != ST_LOAD);
    assign bus.lut_ready = (cur_state == ST_LOAD) && !load_full;
    assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
    assign lut_fire      = bus.lut_valid && bus.lut_ready;
    assign state         = cur_state;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state and datapath decisions; host commands override the
    // per-state behaviour because they are applied last.
    always_comb begin
        next_state      = cur_state;
        step_next       = dds_step;
        saved_next      = saved_step;
        stop_next       = stop_step;
        byte_cnt_next   = byte_cnt;
        load_full_next  = load_full;
        dwell_next      = dwell;
        dwell_cnt_next  = dwell_cnt;
        inc_next        = inc;
        load_done_next  = 1'b0;
        sweep_done_next = 1'b0;
        // 33-bit sum keeps the carry so a wrapping step still clamps.
        sum             = {1'b0, dds_step} + {17'd0, inc};

        case (cur_state)
            ST_LOAD: begin
                if (lut_fire) begin
                    byte_cnt_next = byte_cnt + 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        load_full_next = 1'b1;
                        load_done_next = 1'b1;
                    end
                end
                // Final byte is being written this cycle; resume afterwards.
                if (load_full) begin
                    load_full_next = 1'b0;
                    step_next      = saved_step;
                    next_state     = (saved_step != 32'd0) ? ST_RUN : ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (dwell_cnt == 16'd0) begin
                    if (sum >= {1'b0, stop_step}) begin
                        step_next       = stop_step;
                        sweep_done_next = 1'b1;
                        next_state      = (stop_step != 32'd0) ? ST_RUN : ST_IDLE;
                    end else begin
                        step_next      = sum[31:0];
                        dwell_cnt_next = dwell;
                    end
                end else begin
                    dwell_cnt_next = dwell_cnt - 16'd1;
                end
            end
            default: ;
        endcase

        if (cmd_fire) begin
            case (bus.cmd_op)
                OP_SET_STEP: begin
                    step_next       = bus.cmd_data;
                    sweep_done_next = 1'b0;
                    next_state      = (bus.cmd_data != 32'd0) ? ST_RUN : ST_IDLE;
                end
                OP_LOAD_LUT: begin
                    saved_next      = dds_step;
                    step_next       = 32'd0;
                    byte_cnt_next   = '0;
                    load_full_next  = 1'b0;
                    sweep_done_next = 1'b0;
                    next_state      = ST_LOAD;
                end
                OP_SET_STOP: begin
                    stop_next = bus.cmd_data;
                end
                OP_START_SWEEP: begin
                    dwell_next      = bus.cmd_data[31:16];
                    inc_next        = bus.cmd_data[15:0];
                    dwell_cnt_next  = bus.cmd_data[31:16];
                    step_next       = dds_step;
                    sweep_done_next = 1'b0;
                    next_state      = ST_SWEEP;
                end
            endcase
        end
    end

    // Registered datapath and output strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            dds_step   <= 32'd0;
            saved_step <= 32'd0;
            stop_step  <= 32'd0;
            byte_cnt   <= '0;
            load_full  <= 1'b0;
            dwell      <= 16'd0;
            dwell_cnt  <= 16'd0;
            inc        <= 16'd0;
            dds_cfg    <= 8'd0;
            dds_cfg_ce <= 1'b0;
            load_done  <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            dds_step   <= step_next;
            saved_step <= saved_next;
            stop_step  <= stop_next;
            byte_cnt   <= byte_cnt_next;
            load_full  <= load_full_next;
            dwell      <= dwell_next;
            dwell_cnt  <= dwell_cnt_next;
            inc        <= inc_next;
            dds_cfg_ce <= lut_fire;
            if (lut_fire) begin
                dds_cfg <= bus.lut_data;
            end
            load_done  <= load_done_next;
            sweep_done <= sweep_done_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dds_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_dds_ctrl                                          |
// | Description : Directed self-checking bench for dds_ctrl.           |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_dds_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  dds_cfg;
    logic        dds_cfg_ce;
    logic [31:0] dds_step;
    logic [1:0]  state;
    logic        load_done;
    logic        sweep_done;

    int checks = 0;
    int errors = 0;

    dds_ctrl_if bus ();

    dds_ctrl #(.LUT_DEPTH(4096)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .dds_cfg    (dds_cfg),
        .dds_cfg_ce (dds_cfg_ce),
        .dds_step   (dds_step),
        .state      (state),
        .load_done  (load_done),
        .sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command; returns just after the accepting edge.
    task automatic cmd(input logic [1:0] op, input logic [31:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent, ce_cnt, cyc;
        int bad_data, bad_step, bad_rdy, bad_done, sd_cnt;
        logic tog, acc, done_seen;

        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_data  = 32'd0;
        bus.lut_valid = 1'b0;
        bus.lut_data  = 8'd0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_state", state, 32'd0);
        check("rst_step", dds_step, 32'd0);
        check("rst_cfg", dds_cfg, 32'd0);
        check("rst_ce", dds_cfg_ce, 32'd0);
        check("rst_load_done", load_done, 32'd0);
        check("rst_sweep_done", sweep_done, 32'd0);
        check("rst_cmd_ready", bus.cmd_ready, 32'd1);
        check("rst_lut_ready", bus.lut_ready, 32'd0);

        // SET_STEP nonzero then zero
        cmd(2'd0, 32'h0100_0000);
        check("set_step_val", dds_step, 32'h0100_0000);
        check("set_step_run", state, 32'd1);
        cmd(2'd0, 32'd0);
        check("set_step0_val", dds_step, 32'd0);
        check("set_step0_idle", state, 32'd0);

        // Full LUT load from RUN with a command held pending throughout
        cmd(2'd0, 32'h10);
        cmd(2'd1, 32'd0);
        check("load_state", state, 32'd2);
        check("load_step0", dds_step, 32'd0);
        check("load_cmd_ready", bus.cmd_ready, 32'd0);
        check("load_lut_ready", bus.lut_ready, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd0;
        bus.cmd_data  = 32'h33;
        sent = 0; ce_cnt = 0; cyc = 0; tog = 1'b0; done_seen = 1'b0;
        bad_data = 0; bad_step = 0; bad_rdy = 0; bad_done = 0;
        while (!done_seen && cyc < 20000) begin
            bus.lut_valid = (sent < 4096) && tog;
            bus.lut_data  = sent[7:0];
            acc = bus.lut_valid && bus.lut_ready;
            step();
            cyc++;
            tog = ~tog;
            if (acc) sent++;
            if (sent == 4096 && bus.lut_ready !== 1'b0) bad_rdy++;
            if (bus.cmd_ready !== 1'b0) bad_rdy++;
            if (dds_cfg_ce === 1'b1) begin
                if (dds_cfg !== ce_cnt[7:0]) bad_data++;
                ce_cnt++;
            end
            if (dds_step !== 32'd0) bad_step++;
            if (load_done === 1'b1) begin
                done_seen = 1'b1;
                if (dds_cfg_ce !== 1'b1 || ce_cnt != 4096) bad_done++;
            end
        end
        bus.lut_valid = 1'b0;
        check("load_done_seen", done_seen, 32'd1);
        check("load_bytes_sent", sent, 32'd4096);
        check("load_ce_count", ce_cnt, 32'd4096);
        check("load_cfg_data_errs", bad_data, 32'd0);
        check("load_step_nonzero", bad_step, 32'd0);
        check("load_ready_errs", bad_rdy, 32'd0);
        check("load_done_align", bad_done, 32'd0);
        step();
        check("post_load_state", state, 32'd1);
        check("post_load_step", dds_step, 32'h10);
        check("post_load_cmd_ready", bus.cmd_ready, 32'd1);
        check("post_load_ce", dds_cfg_ce, 32'd0);
        step();
        bus.cmd_valid = 1'b0;
        check("held_cmd_accepted", dds_step, 32'h33);

        // Sweep 90 -> 100 by 4, dwell 2
        cmd(2'd2, 32'd100);
        cmd(2'd0, 32'd90);
        cmd(2'd3, {16'd2, 16'd4});
        check("sweep_state", state, 32'd3);
        step(); step();
        check("sweep_hold", dds_step, 32'd90);
        step();
        check("sweep_94", dds_step, 32'd94);
        step(); step(); step();
        check("sweep_98", dds_step, 32'd98);
        check("sweep_no_done", sweep_done, 32'd0);
        step(); step(); step();
        check("sweep_100", dds_step, 32'd100);
        check("sweep_done", sweep_done, 32'd1);
        check("sweep_end_run", state, 32'd1);
        step();
        check("sweep_done_pulse", sweep_done, 32'd0);

        // Carry path clamp
        cmd(2'd2, 32'hFFFF_FFF0);
        cmd(2'd0, 32'hFFFF_FFE0);
        cmd(2'd3, {16'd0, 16'hFFFF});
        step();
        check("carry_clamp", dds_step, 32'hFFFF_FFF0);
        check("carry_done", sweep_done, 32'd1);

        // Sweep aborted by SET_STEP
        cmd(2'd2, 32'd1000);
        cmd(2'd0, 32'd10);
        cmd(2'd3, {16'd1, 16'd5});
        step(); step();
        check("abort_pre_15", dds_step, 32'd15);
        cmd(2'd0, 32'd7);
        check("abort_step", dds_step, 32'd7);
        check("abort_state", state, 32'd1);
        sd_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (sweep_done !== 1'b0) sd_cnt++;
            step();
        end
        check("abort_no_done", sd_cnt, 32'd0);
        check("abort_step_hold", dds_step, 32'd7);

        // inc=0 below stop: holds forever
        cmd(2'd2, 32'd50);
        cmd(2'd0, 32'd20);
        cmd(2'd3, {16'd0, 16'd0});
        sd_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (sweep_done !== 1'b0) sd_cnt++;
        end
        check("inc0_no_done", sd_cnt, 32'd0);
        check("inc0_state", state, 32'd3);
        check("inc0_step", dds_step, 32'd20);

        // Restart from above stop: completes at first dwell expiry
        cmd(2'd0, 32'd60);
        cmd(2'd3, {16'd1, 16'd3});
        step();
        check("above_stop_wait", dds_step, 32'd60);
        step();
        check("above_stop_clamp", dds_step, 32'd50);
        check("above_stop_done", sweep_done, 32'd1);

        // Reset in the middle of a load
        cmd(2'd0, 32'h20);
        cmd(2'd1, 32'd0);
        bus.lut_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            bus.lut_data = 8'(i);
            step();
        end
        bus.lut_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_state", state, 32'd0);
        check("mid_rst_step", dds_step, 32'd0);
        check("mid_rst_cfg", dds_cfg, 32'd0);
        check("mid_rst_ce", dds_cfg_ce, 32'd0);
        check("mid_rst_load_done", load_done, 32'd0);
        check("mid_rst_lut_ready", bus.lut_ready, 32'd0);
        check("mid_rst_cmd_ready", bus.cmd_ready, 32'd1);

        // Stop register cleared by reset: sweep from 0 ends at once in IDLE
        cmd(2'd3, {16'd0, 16'd1});
        step();
        check("rst_stop_done", sweep_done, 32'd1);
        check("rst_stop_idle", state, 32'd0);
        check("rst_stop_step", dds_step, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
